node_nic: RTL and testbench

- Node-side network interface; sits at the far end of one router port, opposite the router's in/out buffers.
- TX: queues 32-bit pkt_t packets from the node and serialises each into four bytes on the put/payload link into the router.
- RX: deserialises bytes from the router back into pkt_t packets and queues them for the node.
- Link flow control uses the free/put/payload handshake.

---
 rtl/node_nic.sv | 236 +++++++++++++++++++++++
 tb/tb_node_nic.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_nic.sv
// -----------------------------------------------------------------------------
// node_nic
//   Node-side network interface for one router port.
//   TX path: packet FIFO from the node, serialised MSB-first into four bytes on
//            the put/payload link towards the router (zero-gap back-to-back).
//   RX path: bytes from the router are reassembled into packets and queued for
//            the node; truncated, overflowing and (optionally) misaddressed
//            packets are dropped and counted.
//
//   Packet layout: {sourceID[31:28], destID[27:24], data[23:0]}
//
//   Ports:
//     clk, rst_b                  clock, asynchronous active-low reset
//     pkt_in/_valid/_ready        node -> NIC packet handshake
//     free_outbound               router can take one whole packet
//     put_outbound, payload_outbound   serial byte stream to router
//     put_inbound, payload_inbound     serial byte stream from router
//     free_inbound                NIC can take one whole packet
//     pkt_out/_valid/_ready       NIC -> node packet handshake
//     rx_drop_count               saturating count of dropped RX packets
//
//   Build option: define NIC_DEST_CHECK_EN to drop received packets whose
//   destID differs from NODEID.
// -----------------------------------------------------------------------------
module node_nic #(
  parameter int NODEID    = 0,
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_valid,
  output logic        pkt_in_ready,
  input  logic        free_outbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  output logic        free_inbound,
  output logic [31:0] pkt_out,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  output logic [7:0]  rx_drop_count
);

  localparam int DATA_W = 32;
  localparam int TXA    = $clog2(TXQ_DEPTH);
  localparam int TXC    = TXA + 1;
  localparam int RXA    = $clog2(RXQ_DEPTH);
  localparam int RXC    = RXA + 1;
  localparam logic [3:0] NODE_ID4 = 4'(NODEID);
`ifdef NIC_DEST_CHECK_EN
  localparam bit DEST_CHECK = 1'b1;
`else
  localparam bit DEST_CHECK = 1'b0;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // TX packet FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem [TXQ_DEPTH];
  logic [TXA-1:0]    tx_wr, tx_rd;
  logic [TXC-1:0]    tx_cnt;
  logic              tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign pkt_in_ready = (tx_cnt != TXC'(TXQ_DEPTH));
  assign tx_push      = pkt_in_valid && pkt_in_ready;
  assign tx_head      = tx_mem[tx_rd];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= pkt_in;
  end

  // ---------------------------------------------------------------------------
  // TX serialiser FSM (registered put/payload)
  // ---------------------------------------------------------------------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t   tx_state, tx_state_nxt;
  logic [1:0]  tx_idx, tx_idx_nxt;
  logic        put_nxt;
  logic [7:0]  payload_nxt;
  logic [23:0] tx_sh, tx_sh_nxt;
  logic        tx_can_start;

  // free_outbound only matters at a packet boundary.
  assign tx_can_start = (tx_cnt != '0) && free_outbound;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_idx_nxt   = tx_idx;
    put_nxt      = put_outbound;
    payload_nxt  = payload_outbound;
    tx_sh_nxt    = tx_sh;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_can_start) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_SEND;
          tx_idx_nxt   = 2'd0;
          put_nxt      = 1'b1;
          payload_nxt  = tx_head[31:24];
          tx_sh_nxt    = tx_head[23:0];
        end
      end
      TX_SEND: begin
        if (tx_idx != 2'd3) begin
          tx_idx_nxt  = tx_idx + 2'd1;
          payload_nxt = tx_sh[23:16];
          tx_sh_nxt   = {tx_sh[15:0], 8'h00};
        end else if (tx_can_start) begin
          // Next packet follows directly after byte3 with no idle cycle.
          tx_pop      = 1'b1;
          tx_idx_nxt  = 2'd0;
          payload_nxt = tx_head[31:24];
          tx_sh_nxt   = tx_head[23:0];
        end else begin
          tx_state_nxt = TX_IDLE;
          tx_idx_nxt   = 2'd0;
          put_nxt      = 1'b0;
          payload_nxt  = 8'h00;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state         <= TX_IDLE;
      tx_idx           <= 2'd0;
      put_outbound     <= 1'b0;
      payload_outbound <= 8'h00;
    end else begin
      tx_state         <= tx_state_nxt;
      tx_idx           <= tx_idx_nxt;
      put_outbound     <= put_nxt;
      payload_outbound <= payload_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh <= tx_sh_nxt;
  end

  // ---------------------------------------------------------------------------
  // RX deserialiser
  // ---------------------------------------------------------------------------
  logic [1:0]        rx_bcnt;
  logic [23:0]       rx_acc;
  logic [DATA_W-1:0] rx_pkt;
  logic              rx_assembling, rx_complete, rx_trunc, rx_dest_ok;
  logic              rx_full, rx_push, rx_pop, rx_drop;

  assign rx_assembling = (rx_bcnt != 2'd0);
  assign rx_pkt        = {rx_acc, payload_inbound};
  assign rx_complete   = put_inbound && (rx_bcnt == 2'd3);
  assign rx_trunc      = !put_inbound && rx_assembling;
  assign rx_dest_ok    = !DEST_CHECK || (rx_pkt[27:24] == NODE_ID4);
  // A pop on the same edge frees a slot for the completing packet.
  assign rx_push       = rx_complete && rx_dest_ok && (!rx_full || rx_pop);
  assign rx_drop       = rx_trunc || (rx_complete && !rx_push);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_bcnt       <= 2'd0;
      rx_drop_count <= 8'h00;
    end else begin
      // Counter wraps 3 -> 0 on the completing byte; a gap mid-packet aborts.
      rx_bcnt <= put_inbound ? rx_bcnt + 2'd1 : 2'd0;
      if (rx_drop) rx_drop_count <= sat_inc8(rx_drop_count);
    end
  end

  always_ff @(posedge clk) begin
    if (put_inbound) rx_acc <= {rx_acc[15:0], payload_inbound};
  end

  // ---------------------------------------------------------------------------
  // RX packet FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_mem [RXQ_DEPTH];
  logic [RXA-1:0]    rx_wr, rx_rd;
  logic [RXC-1:0]    rx_cnt;

  assign rx_full       = (rx_cnt == RXC'(RXQ_DEPTH));
  assign pkt_out_valid = (rx_cnt != '0);
  assign pkt_out       = rx_mem[rx_rd];
  assign rx_pop        = pkt_out_valid && pkt_out_ready;
  // A packet in progress already owns a slot.
  assign free_inbound  = (rx_cnt + RXC'(rx_assembling)) < RXC'(RXQ_DEPTH);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_pkt;
  end

endmodule

// File: tb/tb_node_nic.sv
module tb_node_nic;

  localparam int NODEID_TB = 3;
  localparam int TXQ_D     = 4;
  localparam int RXQ_D     = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] pkt_in;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic        free_outbound;
  logic        put_outbound;
  logic [7:0]  payload_outbound;
  logic        put_inbound;
  logic [7:0]  payload_inbound;
  logic        free_inbound;
  logic [31:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic [7:0]  rx_drop_count;

  node_nic #(.NODEID(NODEID_TB), .TXQ_DEPTH(TXQ_D), .RXQ_DEPTH(RXQ_D)) dut (
    .clk(clk), .rst_b(rst_b),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .free_outbound(free_outbound), .put_outbound(put_outbound),
    .payload_outbound(payload_outbound),
    .put_inbound(put_inbound), .payload_inbound(payload_inbound),
    .free_inbound(free_inbound),
    .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .rx_drop_count(rx_drop_count)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int exp_drops  = 0;
  int tx_run     = 0;
  bit stim_done  = 0;

  logic [7:0]  tx_exp_q[$];
  logic [31:0] rx_exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which received packets the node should see.
  function automatic bit dest_ok(input logic [31:0] p);
`ifdef NIC_DEST_CHECK_EN
    return p[27:24] == 4'(NODEID_TB);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int sat255(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Offer a packet until accepted; on acceptance its four link bytes, MSB first,
  // become expected output.
  task automatic push_tx(input logic [31:0] p);
    pkt_in = p;
    pkt_in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pkt_in_ready) begin
        tick();
        pkt_in_valid = 1'b0;
        for (int b = 0; b < 4; b++) tx_exp_q.push_back(p[31-8*b -: 8]);
        return;
      end
      tick();
    end
    pkt_in_valid = 1'b0;
    flag("tx_push_timeout");
  endtask

  // Drive nb bytes of p; fewer than four is a truncated burst.
  task automatic rx_pkt(input logic [31:0] p, input int nb);
    for (int i = 0; i < nb; i++) begin
      put_inbound = 1'b1;
      payload_inbound = p[31-8*i -: 8];
      tick();
    end
    put_inbound = 1'b0;
    payload_inbound = 8'h00;
    if (nb == 4) begin
      if (dest_ok(p)) rx_exp_q.push_back(p);
      else exp_drops = sat255(exp_drops);
    end else begin
      exp_drops = sat255(exp_drops);
      tick();
    end
  endtask

  task automatic wait_put();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (put_outbound) return;
    end
    flag("tx_wait_put_timeout");
  endtask

  task automatic drain();
    free_outbound = 1'b1;
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tx_exp_q.size() == 0 && rx_exp_q.size() == 0 && !put_outbound && !pkt_out_valid) break;
      tick();
    end
    repeat (3) tick();
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("rx_queue_drained", rx_exp_q.size(), 0);
  endtask

  // Monitor: compare every presented byte / popped packet with the scoreboard.
  always @(negedge clk) begin
    if (!rst_b) begin
      tx_run = 0;
    end else begin
      if (put_outbound) begin
        tx_run++;
        if (tx_exp_q.size() == 0)
          flag($sformatf("tx_extra_byte got put with %h, required no put", payload_outbound));
        else
          check("tx_byte", {24'h0, payload_outbound}, {24'h0, tx_exp_q.pop_front()});
      end else if (tx_run != 0) begin
        check("tx_frame_len_mod4", tx_run % 4, 0);
        tx_run = 0;
      end
      if (pkt_out_valid && pkt_out_ready) begin
        if (rx_exp_q.size() == 0)
          flag($sformatf("rx_extra_pkt got %h, required none", pkt_out));
        else
          check("rx_pkt", pkt_out, rx_exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int nb, rx_model_cnt;

    rst_b = 1'b0;
    pkt_in = '0; pkt_in_valid = 1'b0; free_outbound = 1'b0;
    put_inbound = 1'b0; payload_inbound = 8'h00; pkt_out_ready = 1'b0;
    #1;
    check("reset_put", put_outbound, 0);
    check("reset_payload", payload_outbound, 0);
    check("reset_pkt_out_valid", pkt_out_valid, 0);
    check("reset_free_inbound", free_inbound, 1);
    check("reset_pkt_in_ready", pkt_in_ready, 1);
    check("reset_drop_count", rx_drop_count, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    tick();

    // Basic TX with first-byte latency.
    free_outbound = 1'b1;
    push_tx(32'h1234_5678);
    @(negedge clk);
    check("tx_lat_no_put_yet", put_outbound, 0);
    @(negedge clk);
    check("tx_lat_byte0_put", put_outbound, 1);
    check("tx_lat_byte0_val", payload_outbound, 8'h12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tx_basic_put_held", put_outbound, 1);
    end
    @(negedge clk);
    check("tx_basic_put_end", put_outbound, 0);
    check("tx_basic_payload_idle", payload_outbound, 0);

    // Back-to-back packets: eight consecutive put cycles.
    tick();
    push_tx(32'hA0B0_C0D0);
    push_tx(32'h0102_0304);
    wait_put();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("tx_b2b_no_gap", put_outbound, 1);
    end
    @(negedge clk);
    check("tx_b2b_end", put_outbound, 0);

    // free_outbound gating, and deassertion mid-packet.
    tick();
    free_outbound = 1'b0;
    push_tx(32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tx_gated_no_put", put_outbound, 0);
    end
    free_outbound = 1'b1;
    wait_put();
    @(negedge clk);
    check("tx_gate_byte1", put_outbound, 1);
    free_outbound = 1'b0;
    @(negedge clk);
    check("tx_gate_byte2", put_outbound, 1);
    @(negedge clk);
    check("tx_gate_byte3", put_outbound, 1);
    @(negedge clk);
    check("tx_gate_end", put_outbound, 0);

    // TX full: four accepted, fifth refused.
    tick();
    for (int i = 0; i < 4; i++) push_tx(32'h1100_0000 + 32'(i) * 32'h0101_0101);
    check("tx_full_ready_low", pkt_in_ready, 0);
    pkt_in = 32'hDEAD_BEEF;
    pkt_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tx_full_fifth_refused", pkt_in_ready, 0);
    end
    pkt_in_valid = 1'b0;
    free_outbound = 1'b1;
    drain();

    // Basic RX.
    pkt_out_ready = 1'b0;
    p = 32'h3011_2233;
    for (int i = 0; i < 3; i++) begin
      put_inbound = 1'b1; payload_inbound = p[31-8*i -: 8]; tick();
    end
    @(negedge clk);
    check("rx_valid_before_byte3", pkt_out_valid, 0);
    payload_inbound = p[7:0];
    tick();
    put_inbound = 1'b0; payload_inbound = 8'h00;
    if (dest_ok(p)) rx_exp_q.push_back(p); else exp_drops = sat255(exp_drops);
    rx_model_cnt = dest_ok(p) ? 1 : 0;
    @(negedge clk);
    check("rx_valid_after_byte3", pkt_out_valid, 32'(dest_ok(p)));
    if (dest_ok(p)) check("rx_basic_pkt", pkt_out, p);
    check("rx_free_one_held", free_inbound, 32'(rx_model_cnt < RXQ_D));

    // Second packet: free_inbound reflects the slot claimed by byte0.
    p = 32'h23AA_BBCC;
    put_inbound = 1'b1; payload_inbound = p[31:24];
    tick();
    @(negedge clk);
    check("rx_free_after_byte0", free_inbound, 32'((rx_model_cnt + 1) < RXQ_D));
    for (int i = 1; i < 4; i++) begin
      payload_inbound = p[31-8*i -: 8]; tick();
    end
    put_inbound = 1'b0; payload_inbound = 8'h00;
    rx_exp_q.push_back(p);
    pkt_out_ready = 1'b1;
    repeat (4) tick();

    // Truncated burst.
    rx_pkt(32'hAABB_0000, 2);
    @(negedge clk);
    check("rx_trunc_drop_count", rx_drop_count, exp_drops);
    check("rx_trunc_no_write", pkt_out_valid, 0);

    // Destination filter.
    rx_pkt({4'h1, 4'h5, 24'hABCDEF}, 4);
    repeat (3) tick();
    check("rx_dest_drop_count", rx_drop_count, exp_drops);
    check("rx_dest_queue", rx_exp_q.size(), 0);

    // Reset during TX byte2.
    free_outbound = 1'b1;
    push_tx(32'h7766_5544);
    wait_put();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("rst_mid_put", put_outbound, 0);
    check("rst_mid_payload", payload_outbound, 0);
    check("rst_mid_drop", rx_drop_count, 0);
    tx_exp_q.delete();
    rx_exp_q.delete();
    exp_drops = 0;
    @(negedge clk);
    #2;
    rst_b = 1'b1;
    tick();
    check("rst_after_tx_empty", pkt_in_ready, 1);
    check("rst_after_rx_empty", pkt_out_valid, 0);
    check("rst_after_free_in", free_inbound, 1);
    repeat (8) tick();

    // Randomized traffic on both paths.
    fork
      begin
        fork
          begin
            for (int k = 0; k < 40; k++) begin
              push_tx($urandom);
              repeat ($urandom_range(0, 3)) tick();
            end
          end
          begin
            for (int k = 0; k < 40; k++) begin
              for (int w = 0; w < 200 && !free_inbound; w++) tick();
              if (!free_inbound) flag("rx_free_wait_timeout");
              p = {4'($urandom), ($urandom_range(0, 1) != 0) ? 4'(NODEID_TB) : 4'($urandom),
                   24'($urandom)};
              nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 4;
              rx_pkt(p, nb);
              repeat ($urandom_range(0, 2)) tick();
            end
          end
        join
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin free_outbound = 1'($urandom_range(0, 1)); tick(); end
      end
      begin
        while (!stim_done) begin pkt_out_ready = 1'($urandom_range(0, 1)); tick(); end
      end
    join
    drain();
    check("rand_drop_count", rx_drop_count, exp_drops);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) rx_pkt(32'h5500_0000, 1);
    tick();
    check("drop_count_saturates", rx_drop_count, exp_drops);
    check("drop_count_is_255", rx_drop_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
